// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Width of a counter that indexes n digits (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// One DIGIT-wide slice of the serial subtractor: d = x - y - bin, bo = borrow.
module digit_subtractor #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] w_sum;

  // The extra top bit goes negative exactly when the slice needs a borrow.
  assign w_sum = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
  assign d     = w_sum[DIGIT-1:0];
  assign bo    = w_sum[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial a - b with valid/ready handshakes on both sides.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  sub_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [DIGIT-1:0] w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_diff_shift;

  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .x   (r_a[DIGIT-1:0]),
    .y   (r_b[DIGIT-1:0]),
    .bin (r_borrow),
    .d   (w_d),
    .bo  (w_bo)
  );

  // New digits enter at the top so the first (least significant) one ends up at bit 0.
  if (DIGIT == WIDTH) begin : g_full
    assign w_diff_shift = w_d;
  end else begin : g_part
    assign w_diff_shift = {w_d, r_diff[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_diff      <= {WIDTH{1'b0}};
      r_borrow    <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_borrow   <= 1'b0;
            r_cnt      <= {CW{1'b0}};
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_diff   <= w_diff_shift;
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_borrow;

`ifdef SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // The last digit's top bit is the result MSB, so overflow is settled on that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
        r_ovf   <= 1'b0;
      end else if (r_state == RUN && r_cnt == LAST_CNT) begin
        r_ovf <= (r_a_msb != r_b_msb) && (w_d[DIGIT-1] != r_a_msb);
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle digit-serial subtractor computing `diff = a - b` over `WIDTH` bits, `DIGIT` bits per clock, with a borrow-out. It is the inverse-direction companion to the team's 16-bit ripple-carry adder. It trades latency for a `DIGIT`-bit-wide datapath. Valid/ready handshakes on both sides let it sit between an operand producer and a result consumer in the arithmetic pipeline.

## Interface
Parameters:
- `WIDTH`, 16, operand and result width in bits.
- `DIGIT`, 1, bits processed per cycle; `WIDTH % DIGIT == 0` is required and is an elaboration error otherwise.

Ports:
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  operands valid.
- `in_ready`  output  1  block can accept operands.
- `a`  input  `WIDTH`  minuend.
- `b`  input  `WIDTH`  subtrahend.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts result.
- `diff`  output  `WIDTH`  `a - b` modulo 2^`WIDTH`.
- `bout`  output  1  borrow-out; 1 iff unsigned `a < b`.
- `ovf`  output  1  signed overflow; present only with `SUB_OVF_EN`.

## Operation
- FSM states: `IDLE`, `RUN`, `DONE`.
- `IDLE`:
  - `in_ready`=1.
  - On `in_valid && in_ready` at the clock edge: latch `a` and `b` into shift registers, clear the borrow register, set the digit counter to 0, then go to `RUN`.
- `RUN`:
  - Each cycle, subtract the low `DIGIT` bits of `b` plus the stored borrow from the low `DIGIT` bits of `a`.
  - Shift both operand registers right by `DIGIT`.
  - Insert the `DIGIT`-bit result at the top of the result shift register.
  - Update the borrow and increment the counter.
  - After N = `WIDTH`/`DIGIT` digits, go to `DONE`.
- `DONE`:
  - `out_valid`=1; `diff`, `bout` and `ovf` are held stable.
  - On `out_ready`, go to `IDLE`.
- `in_ready` is 1 only in `IDLE`; `out_valid` is 1 only in `DONE`.
- Inputs `a`/`b` are ignored outside the acceptance edge.
- Arithmetic:
  - Each digit uses an internal `DIGIT`+1-bit subtraction.
  - `bout` is the final stored borrow.
  - Results are unsigned modulo 2^`WIDTH`.
- Reset values:
  - State `IDLE`; `in_ready`=1; `out_valid`=0.
  - `diff`=0, `bout`=0, `ovf`=0; counter and borrow cleared.
- Reset mid-operation, in `RUN` or `DONE`: the operation is aborted without any result, and the block is back in `IDLE` on the next cycle.
- `out_ready` held high in advance: the result is still presented for exactly one cycle of `out_valid`.
- `out_ready` asserted outside `DONE` has no effect.

## Timing
- Latency: `out_valid` rises N clock edges after the acceptance edge.
  - `WIDTH`=16, `DIGIT`=1 gives N=16.
  - `WIDTH`=16, `DIGIT`=4 gives N=4.
- Throughput: with zero back-pressure, one operation every N+2 cycles (acceptance, N run cycles, one `DONE` cycle, then `IDLE`).
- No combinational path from any input to `in_ready` or `out_valid`; all outputs are registered.
- Back-pressure: `DONE` persists indefinitely while `out_ready`=0.

## Configuration
- Macro `SUB_OVF_EN`.
- Defined:
  - Port `ovf` exists.
  - `ovf` = (`a`[MSB] != `b`[MSB]) && (`diff`[MSB] != `a`[MSB]), with the `a`/`b` MSBs captured at acceptance.
  - `ovf` is valid with `out_valid` and is 0 at reset.
- Undefined:
  - No `ovf` port and no MSB capture registers.
  - All other behaviour is identical.

## Structure
- Package `serial_sub_pkg`:
  - State enum typedef `sub_state_t` {`IDLE`, `RUN`, `DONE`}.
  - Counter-width function/constant derived from `WIDTH`/`DIGIT`.
- Sub-module `digit_subtractor`:
  - Combinational, `DIGIT`-wide.
  - Inputs `x`, `y`, `bin`; outputs `d`, `bo`.
  - Instantiated once in the datapath.

## Test plan
- `WIDTH`=16, `DIGIT`=1: accept `a`=0x5678, `b`=0x1234 -> after 16 edges `out_valid`=1, `diff`=0x4444, `bout`=0.
- `a`=0x0000, `b`=0x0001 -> `diff`=0xFFFF, `bout`=1; `a`=0xEF01, `b`=0xABCD -> `diff`=0x4334, `bout`=0.
- `SUB_OVF_EN`:
  - `a`=0x8000, `b`=0x0001 -> `diff`=0x7FFF, `bout`=0, `ovf`=1.
  - `a`=0x7FFF, `b`=0x0001 -> `ovf`=0.
- Back-pressure: hold `out_ready`=0 for 5 cycles in `DONE` -> `diff`/`bout` stable, `in_ready`=0; on `out_ready`=1, one cycle later `in_ready`=1.
- Assert `rst` 3 cycles into `RUN` -> next cycle `in_ready`=1, `out_valid`=0, `diff`=0; a new operation 0x1234-0x1234 then yields 0x0000 with `bout`=0.
- `DIGIT`=4: 0xFFFF-0x0001 -> `out_valid` 4 edges after acceptance, `diff`=0xFFFE, `bout`=0.
